// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared FSM state type and sizing constants for the truth-table sweeper
package tt_sweep_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 5;
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: stimulus, response and status signals between the sweeper and the circuit/board
// master: sweeper side (drives a..d, x/y, status; receives start and circuit outputs)
// slave : environment side (drives start and circuit outputs; observes everything else)
// TT_SWEEP_XNOR_EN adds x, y and h_in for the NOR-built XNOR circuit.
interface truth_table_sweeper_if;
  import tt_sweep_pkg::*;
  logic             start;
  logic             a, b, c, d;
  logic             f_in, g_in;
  logic             busy, done, pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [VEC_W-1:0] first_fail_vec;
`ifdef TT_SWEEP_XNOR_EN
  logic             x, y, h_in;
  modport master (input start, f_in, g_in, h_in,
                  output a, b, c, d, x, y, busy, done, pass, err_count, fail_valid, first_fail_vec);
  modport slave  (output start, f_in, g_in, h_in,
                  input a, b, c, d, x, y, busy, done, pass, err_count, fail_valid, first_fail_vec);
`else
  modport master (input start, f_in, g_in,
                  output a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail_vec);
  modport slave  (output start, f_in, g_in,
                  input a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail_vec);
`endif
endinterface

// File: rtl/tt_sweep_golden.sv
// tt_sweep_golden: combinational reference for F and G (and H under TT_SWEEP_XNOR_EN)
// vec = {A,B,C,D}, A is the MSB; h_exp is the XNOR of vec[1] and vec[0].
module tt_sweep_golden
  import tt_sweep_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
`ifdef TT_SWEEP_XNOR_EN
  output logic             h_exp,
`endif
  output logic             f_exp,
  output logic             g_exp
);
  logic abc;
  assign abc   = vec[3] & vec[2] & vec[1];
  assign f_exp = (~vec[3] & vec[0]) | abc;
  assign g_exp = (~vec[3] & ~vec[0]) | abc;
`ifdef TT_SWEEP_XNOR_EN
  assign h_exp = ~(vec[1] ^ vec[0]);
`endif
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives all 16 {a,b,c,d} vectors, samples the circuit after SETTLE extra cycles and checks it
// Ports: clk, rst (async active-high), bus (truth_table_sweeper_if.master).
// SETTLE (0..15): extra hold cycles per vector before sampling.
// TT_SWEEP_XNOR_EN: also drives x/y and checks h_in against the XNOR reference.
module truth_table_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.master bus
);
  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d, first_q, first_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic             f_exp, g_exp, mis;
`ifdef TT_SWEEP_XNOR_EN
  logic             h_exp;
  tt_sweep_golden u_golden (.vec(vec_q), .h_exp(h_exp), .f_exp(f_exp), .g_exp(g_exp));
  assign mis = (bus.f_in != f_exp) | (bus.g_in != g_exp) | (bus.h_in != h_exp);
  assign bus.x = vec_q[1];
  assign bus.y = vec_q[0];
`else
  tt_sweep_golden u_golden (.vec(vec_q), .f_exp(f_exp), .g_exp(g_exp));
  assign mis = (bus.f_in != f_exp) | (bus.g_in != g_exp);
`endif
  // a vector counts once however many outputs mismatch; vec holds at 15 into DONE
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    first_d = first_q;
    if (state_q != RUN) begin
      if (bus.start) begin
        state_d = RUN;
        vec_d   = '0;
        cnt_d   = '0;
        err_d   = '0;
        fv_d    = 1'b0;
        first_d = '0;
      end
    end else if (cnt_q == SETTLE_C) begin
      cnt_d   = '0;
      err_d   = err_q + ERR_W'(mis);
      fv_d    = fv_q | mis;
      first_d = (mis && !fv_q) ? vec_q : first_q;
      vec_d   = (vec_q == LAST_VEC) ? vec_q : vec_q + 1'b1;
      state_d = (vec_q == LAST_VEC) ? DONE : RUN;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      first_q <= first_d;
    end
  end
  assign {bus.a, bus.b, bus.c, bus.d} = vec_q;
  assign bus.busy           = state_q == RUN;
  assign bus.done           = state_q == DONE;
  assign bus.pass           = (state_q == DONE) && (err_q == '0);
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_vec = first_q;
endmodule
